adder_result_queue: RTL and testbench
=====================================

Name: adder_result_queue

Overview:
- Downstream stage of the iCE40 DSP (SB_MAC16) 32-bit adder. The adder registers its inputs, so its sum appears a fixed number of cycles after the operands are presented.
- This block tracks operations in flight through the adder and captures each sum, with its tag, into an in-order result FIFO.
- It presents results to the consumer through a valid/ready interface.
- It gives the operand issuer a credit-based issue_ready, so a sum always has a free FIFO slot when it arrives. The adder itself has no backpressure.

Parameters:
- WIDTH, 32, data width of sum_in and res_data.
- LATENCY, 1, cycles from operands presented to adder until sum_in is valid. Legal range 1..4.
- DEPTH, 4, result FIFO entries. Power of two, 2..16.
- TAG_W, 5, width of the tag carried with each operation (e.g. a destination register index).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- issue_valid  in  1  issuer presented operands to the adder this cycle.
- issue_tag  in  TAG_W  tag for the issued operation.
- issue_ready  out  1  issuer may issue this cycle.
- sum_in  in  WIDTH  adder output.
- flush  in  1  synchronous discard of all queued and in-flight operations.
- res_valid  out  1  head result available.
- res_data  out  WIDTH  head sum.
- res_tag  out  TAG_W  head tag.
- res_ready  in  1  consumer accepts the head result.
- occupancy  out  $clog2(DEPTH+1)  number of valid FIFO entries.
- inflight  out  $clog2(LATENCY+1)  number of operations inside the adder.
- overflow_err  out  1  sticky: issue attempted while issue_ready=0.

Behaviour:
- Reset (sync, reset=1 at a rising edge):
  - FIFO is emptied and pointers are zeroed.
  - Delay-line valid bits are cleared.
  - overflow_err is cleared.
  - Outputs after reset: res_valid=0, res_data=0, res_tag=0, occupancy=0, inflight=0, issue_ready=1.
- Issue:
  - An issue is accepted when issue_valid && issue_ready && !flush.
  - An accepted issue enters stage 0 of a LATENCY-deep delay line of {valid, tag}.
  - issue_valid with issue_ready=0 is dropped and sets overflow_err=1 on the next edge.
- Credit:
  - issue_ready = (occupancy + inflight) < DEPTH.
  - It is computed from registered state only; it does not depend on res_ready or issue_valid.
  - A pop in the current cycle frees credit in the next cycle, not the current one.
- Arrival:
  - When the last delay-line stage is valid, sum_in is sampled in that cycle and pushed, with its tag, at the closing edge.
  - The credit rule guarantees the FIFO is never full on arrival. A bench assertion must check this.
- Latency:
  - Issue in cycle t → sum_in sampled in cycle t+LATENCY.
  - With the FIFO empty, res_valid=1 in cycle t+LATENCY+1 with res_data equal to that sum.
- Output:
  - First-word fall-through.
  - res_data and res_tag are forced to 0 whenever res_valid=0.
  - Pop when res_valid && res_ready. res_ready with res_valid=0 has no effect.
- Simultaneous push and pop: occupancy is unchanged. A push into an empty FIFO is not bypassed to the output in the same cycle.
- Pointers: wrap modulo DEPTH. Full/empty are resolved from occupancy, not from pointer equality.
- Throughput: with res_ready held 1, one result per cycle is sustained indefinitely.
- Flush:
  - At the edge where flush=1: FIFO emptied, all delay-line valid bits cleared.
  - Any issue or arrival in the flush cycle is discarded.
  - The next cycle shows res_valid=0, occupancy=0, inflight=0, issue_ready=1.
  - Sums that emerge later for flushed operations are ignored.
  - overflow_err is not cleared by flush.
- Reset mid-operation: identical to flush, plus overflow_err is cleared.
- Ordering: results leave strictly in issue order. Tags are not interpreted.

Decomposition:
- Shared package (alu/adder defines) holds:
  - ADD_LATENCY: the DSP adder's latency, 1 with input registers.
  - XLEN=32.
  - RQ_TAG_W=5.
  - The default RQ_DEPTH.
- The top-level instantiation passes ADD_LATENCY into LATENCY, keeping the adder and this queue matched.
- One sub-module: result_fifo.
  - Synchronous, fall-through, DEPTH x (WIDTH+TAG_W).
  - Ports: push, pop, data in/out, occupancy.
  - Memory is inferred as distributed registers.
- The delay line and credit logic stay in the top module.

Test Plan:
1. Reset: hold reset 2 cycles with random inputs → all outputs 0, issue_ready=1; then issue_valid=0 for 5 cycles → occupancy stays 0.
2. Single op: issue tag=3 in cycle t; drive sum_in=32'd12 in cycle t+1 → res_valid=1, res_data=12, res_tag=3 in cycle t+2; pop → res_valid=0 next cycle.
3. Backpressure, DEPTH=4, res_ready=0: issue 4 ops back-to-back → issue_ready=0 from the cycle after the 4th issue, occupancy reaches 4; 5th issue_valid → overflow_err=1, occupancy stays 4; one pop → issue_ready=1 the next cycle.
4. Streaming: res_ready=1 and an issue every cycle for 20 cycles, sums 100..119 → 20 results in order, one per cycle, occupancy ≤1, overflow_err=0.
5. Flush: 2 entries queued and 1 in flight, assert flush → next cycle occupancy=0, inflight=0, res_valid=0; the in-flight sum arriving afterwards is not pushed.
6. Wrap and random: 200 ops, tags 0..31 cycling, random res_ready (50%), issue whenever issue_ready, LATENCY=1 and 3 → scoreboard matches data and tag in order; FIFO-never-full-on-arrival assertion holds.

Source files
------------

// File: rtl/adder_result_queue_pkg.sv
// Shared adder/ALU definitions for the SB_MAC16 32-bit adder and the queue that
// collects its results.
package adder_result_queue_pkg;

  localparam int XLEN        = 32;
  localparam int ADD_LATENCY = 1;  // SB_MAC16 adder with its input registers enabled
  localparam int RQ_TAG_W    = 5;
  localparam int RQ_DEPTH    = 4;

  // Bits needed to hold any count from 0 to n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/adder_result_queue_result_fifo.sv
// In-order, first-word fall-through FIFO of DEPTH x DW bits held in plain
// registers. Full/empty come from the entry count, so pointers simply wrap.
module result_fifo
  import adder_result_queue_pkg::*;
#(
  parameter int DEPTH = RQ_DEPTH,
  parameter int DW    = XLEN + RQ_TAG_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [DW-1:0]              wdata,
  input  logic                       pop,
  output logic [DW-1:0]              rdata,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = cnt_w(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [OW-1:0] count_r;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;

  assign full_s  = (count_r == OW'(DEPTH));
  assign empty_s = (count_r == '0);
  assign push_s  = push && !full_s && !clear;
  assign pop_s   = pop && !empty_s && !clear;

  // Entry storage; no reset needed since only the pointers decide what is live.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and entry count.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_r + OW'(push_s) - OW'(pop_s);
    end
  end

  assign rdata     = mem_r[rd_ptr_r];
  assign occupancy = count_r;

endmodule

// File: rtl/adder_result_queue.sv
// Tracks operations inside the SB_MAC16 adder and queues each sum with its tag,
// in issue order, behind a credit-based issue_ready so every sum finds a free slot.
module adder_result_queue
  import adder_result_queue_pkg::*;
#(
  parameter int WIDTH   = XLEN,
  parameter int LATENCY = ADD_LATENCY,
  parameter int DEPTH   = RQ_DEPTH,
  parameter int TAG_W   = RQ_TAG_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         issue_valid,
  input  logic [TAG_W-1:0]             issue_tag,
  output logic                         issue_ready,
  input  logic [WIDTH-1:0]             sum_in,
  input  logic                         flush,
  output logic                         res_valid,
  output logic [WIDTH-1:0]             res_data,
  output logic [TAG_W-1:0]             res_tag,
  input  logic                         res_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [$clog2(LATENCY+1)-1:0] inflight,
  output logic                         overflow_err
);

  localparam int OW = cnt_w(DEPTH);
  localparam int IW = cnt_w(LATENCY);
  localparam int CW = OW + IW;

  logic [LATENCY-1:0]     stage_valid_r;
  logic [TAG_W-1:0]       stage_tag_r [LATENCY];
  logic [IW-1:0]          inflight_r;
  logic                   overflow_r;
  logic                   accept_s;
  logic                   arrive_s;
  logic                   pop_s;
  logic [CW-1:0]          credit_used_s;
  logic [WIDTH+TAG_W-1:0] head_s;

  // Credit counts both queued results and sums still inside the adder.
  assign credit_used_s = CW'(occupancy) + CW'(inflight_r);
  assign issue_ready   = (credit_used_s < CW'(DEPTH));
  assign accept_s      = issue_valid && issue_ready && !flush;
  assign arrive_s      = stage_valid_r[LATENCY-1];
  assign res_valid     = (occupancy != '0);
  assign pop_s         = res_valid && res_ready;

  // Delay-line valid bits; clearing them makes sums of flushed ops invisible.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      stage_valid_r <= '0;
    end else begin
      stage_valid_r[0] <= accept_s;
      for (int i = 1; i < LATENCY; i++) begin
        stage_valid_r[i] <= stage_valid_r[i-1];
      end
    end
  end

  // Delay-line tags, qualified by the valid bits above.
  always_ff @(posedge clk) begin
    stage_tag_r[0] <= issue_tag;
    for (int i = 1; i < LATENCY; i++) begin
      stage_tag_r[i] <= stage_tag_r[i-1];
    end
  end

  // Operations currently inside the adder.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      inflight_r <= '0;
    end else begin
      inflight_r <= inflight_r + IW'(accept_s) - IW'(arrive_s);
    end
  end

  // Sticky overflow; survives flush, only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (issue_valid && !issue_ready) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  result_fifo #(
    .DEPTH (DEPTH),
    .DW    (WIDTH + TAG_W)
  ) u_result_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (arrive_s),
    .wdata     ({stage_tag_r[LATENCY-1], sum_in}),
    .pop       (pop_s),
    .rdata     (head_s),
    .occupancy (occupancy)
  );

  // Head fields read as zero while the queue is empty.
  always_comb begin
    res_data = '0;
    res_tag  = '0;
    if (res_valid) begin
      res_data = head_s[WIDTH-1:0];
      res_tag  = head_s[WIDTH +: TAG_W];
    end else begin
      res_data = '0;
      res_tag  = '0;
    end
  end

  assign inflight     = inflight_r;
  assign overflow_err = overflow_r;

endmodule

// File: tb/tb_adder_result_queue.sv
// Directed bench for adder_result_queue: one instance at the package latency (1)
// and one at latency 3, both fed by a bench-side adder model in the random phase.
module tb_adder_result_queue;
  import adder_result_queue_pkg::*;

  localparam int W  = XLEN;
  localparam int TW = RQ_TAG_W;
  localparam int D  = RQ_DEPTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic [TW-1:0] issue_tag;
  logic          flush;
  logic          res_ready;
  logic [W-1:0]  sum_a;
  logic [W-1:0]  sum_b;

  logic          ready_a, rv_a, ovf_a;
  logic [W-1:0]  rd_a;
  logic [TW-1:0] rt_a;
  logic [2:0]    occ_a;
  logic [0:0]    inf_a;

  logic          ready_b, rv_b, ovf_b;
  logic [W-1:0]  rd_b;
  logic [TW-1:0] rt_b;
  logic [2:0]    occ_b;
  logic [1:0]    inf_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder_result_queue u_dut_a (
    .clk (clk), .reset (reset), .issue_valid (issue_valid), .issue_tag (issue_tag),
    .issue_ready (ready_a), .sum_in (sum_a), .flush (flush), .res_valid (rv_a),
    .res_data (rd_a), .res_tag (rt_a), .res_ready (res_ready), .occupancy (occ_a),
    .inflight (inf_a), .overflow_err (ovf_a)
  );

  adder_result_queue #(.LATENCY(3)) u_dut_b (
    .clk (clk), .reset (reset), .issue_valid (issue_valid), .issue_tag (issue_tag),
    .issue_ready (ready_b), .sum_in (sum_b), .flush (flush), .res_valid (rv_b),
    .res_data (rd_b), .res_tag (rt_b), .res_ready (res_ready), .occupancy (occ_b),
    .inflight (inf_b), .overflow_err (ovf_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [TW+W-1:0] q_a[$];
    logic [TW+W-1:0] q_b[$];
    logic [TW+W-1:0] exp_e;
    logic            hv [4];
    logic [W-1:0]    hd [4];
    logic            rr, iss, done;
    logic [W-1:0]    val;
    int              issued;

    // 1: reset with random inputs, then idle
    for (int i = 0; i < 2; i++) begin
      reset       = 1'b1;
      issue_valid = 1'($urandom_range(0, 1));
      issue_tag   = TW'($urandom);
      flush       = 1'($urandom_range(0, 1));
      res_ready   = 1'($urandom_range(0, 1));
      sum_a       = W'($urandom);
      sum_b       = W'($urandom);
      @(posedge clk);
    end
    step();
    check("rst_res_valid", rv_a, 0);
    check("rst_res_data", rd_a, 0);
    check("rst_res_tag", rt_a, 0);
    check("rst_occupancy", occ_a, 0);
    check("rst_inflight", inf_a, 0);
    check("rst_issue_ready", ready_a, 1);
    check("rst_overflow", ovf_a, 0);
    check("rst_b_ready", ready_b, 1);
    reset = 1'b0; issue_valid = 1'b0; issue_tag = '0; flush = 1'b0;
    res_ready = 1'b0; sum_a = '0; sum_b = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_occupancy", occ_a, 0);
    end

    // 2: single op, tag 3, sum 12
    issue_valid = 1'b1; issue_tag = 5'd3;
    step();
    check("single_inflight", inf_a, 1);
    check("single_no_early_valid", rv_a, 0);
    issue_valid = 1'b0; sum_a = 32'd12;
    step();
    check("single_valid", rv_a, 1);
    check("single_data", rd_a, 32'd12);
    check("single_tag", rt_a, 5'd3);
    check("single_occ", occ_a, 1);
    res_ready = 1'b1; sum_a = 32'd0;
    step();
    check("single_popped_valid", rv_a, 0);
    check("single_popped_data", rd_a, 0);
    res_ready = 1'b0;

    // 4: streaming, one issue per cycle, sums 100..119
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 23; k++) begin
      check("stream_ready", ready_a, 1);
      check("stream_occ_le1", occ_a <= 3'd1, 1);
      if (k >= 2 && k <= 21) begin
        check("stream_valid", rv_a, 1);
        check("stream_data", rd_a, 100 + k - 2);
        check("stream_tag", rt_a, k - 2);
      end else begin
        check("stream_idle_valid", rv_a, 0);
      end
      issue_valid = (k < 20);
      issue_tag   = TW'(k);
      sum_a       = (k >= 1 && k <= 20) ? W'(100 + k - 1) : W'(0);
      res_ready   = 1'b1;
      step();
    end
    check("stream_overflow", ovf_a, 0);
    issue_valid = 1'b0; res_ready = 1'b0; sum_a = '0;

    // 3: backpressure with res_ready low
    issue_valid = 1'b1; issue_tag = 5'd10;
    step();
    check("bp_c1_ready", ready_a, 1);
    issue_tag = 5'd11; sum_a = 32'd20;
    step();
    check("bp_c2_ready", ready_a, 1);
    check("bp_c2_occ", occ_a, 1);
    issue_tag = 5'd12; sum_a = 32'd21;
    step();
    check("bp_c3_ready", ready_a, 1);
    check("bp_c3_occ", occ_a, 2);
    issue_tag = 5'd13; sum_a = 32'd22;
    step();
    check("bp_c4_ready", ready_a, 0);
    check("bp_c4_occ", occ_a, 3);
    check("bp_c4_inflight", inf_a, 1);
    issue_valid = 1'b0; sum_a = 32'd23;
    step();
    check("bp_full_ready", ready_a, 0);
    check("bp_full_occ", occ_a, 4);
    check("bp_full_overflow", ovf_a, 0);
    issue_valid = 1'b1; issue_tag = 5'd14; sum_a = 32'd99;
    step();
    check("bp_overflow_set", ovf_a, 1);
    check("bp_drop_occ", occ_a, 4);
    check("bp_drop_inflight", inf_a, 0);
    check("bp_pop_cycle_ready", ready_a, 0);
    issue_valid = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_drain_data", rd_a, 20 + i);
      check("bp_drain_tag", rt_a, 10 + i);
      step();
      if (i == 0) check("bp_credit_back", ready_a, 1);
    end
    check("bp_drained_valid", rv_a, 0);
    check("bp_drained_occ", occ_a, 0);
    res_ready = 1'b0;

    // 5: flush with 2 queued and 1 in flight
    issue_valid = 1'b1; issue_tag = 5'd1;
    step();
    issue_tag = 5'd2; sum_a = 32'd50;
    step();
    issue_tag = 5'd3; sum_a = 32'd51;
    step();
    check("fl_pre_occ", occ_a, 2);
    check("fl_pre_inflight", inf_a, 1);
    check("fl_pre_data", rd_a, 32'd50);
    flush = 1'b1; issue_tag = 5'd4; sum_a = 32'd52;
    step();
    check("fl_occ", occ_a, 0);
    check("fl_inflight", inf_a, 0);
    check("fl_valid", rv_a, 0);
    check("fl_data", rd_a, 0);
    check("fl_ready", ready_a, 1);
    check("fl_keeps_overflow", ovf_a, 1);
    flush = 1'b0; issue_valid = 1'b0; sum_a = 32'd53;
    step();
    check("fl_late_sum_ignored", occ_a, 0);

    // 6: random res_ready, 200 ops into both latencies
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rand_rst_overflow", ovf_a, 0);
    for (int k = 0; k < 4; k++) begin
      hv[k] = 1'b0;
      hd[k] = '0;
    end
    issued = 0;
    done   = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      for (int k = 3; k > 0; k--) begin
        hv[k] = hv[k-1];
        hd[k] = hd[k-1];
      end
      if (hv[1]) check("arrive_not_full_a", occ_a < 3'(D), 1);
      if (hv[3]) check("arrive_not_full_b", occ_b < 3'(D), 1);
      rr = 1'($urandom_range(0, 1));
      if (rv_a && rr) begin
        check("sb_a_has_entry", q_a.size() != 0, 1);
        if (q_a.size() != 0) begin
          exp_e = q_a.pop_front();
          check("rand_a_result", {rt_a, rd_a}, exp_e);
        end
      end else if (!rv_a) begin
        check("rand_a_zero_data", rd_a, 0);
      end
      if (rv_b && rr) begin
        check("sb_b_has_entry", q_b.size() != 0, 1);
        if (q_b.size() != 0) begin
          exp_e = q_b.pop_front();
          check("rand_b_result", {rt_b, rd_b}, exp_e);
        end
      end
      iss   = ready_a && ready_b && (issued < 200);
      val   = W'($urandom);
      hv[0] = iss;
      hd[0] = val;
      issue_valid = iss;
      issue_tag   = TW'(issued);
      if (iss) begin
        q_a.push_back({TW'(issued), val});
        q_b.push_back({TW'(issued), val});
        issued++;
      end
      res_ready = rr;
      sum_a = hv[1] ? hd[1] : W'($urandom);
      sum_b = hv[3] ? hd[3] : W'($urandom);
      done  = (issued == 200) && (q_a.size() == 0) && (q_b.size() == 0);
      step();
    end
    check("rand_complete", done, 1);
    check("rand_overflow_a", ovf_a, 0);
    check("rand_overflow_b", ovf_b, 0);
    check("rand_end_occ_a", occ_a, 0);
    check("rand_end_occ_b", occ_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
